// File: rtl/sram_arbiter_ctrl.sv
// Round-robin two-requester sequencer in front of the 1024x32 SRAM wrapper.
// Optional ISSUE watchdog enabled by defining SRAM_TIMEOUT_EN.
module sram_arbiter_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [1:0]                  req,
  input  logic [1:0]                  req_write,
  input  logic [1:0][ADDR_W-1:0]      req_addr,
  input  logic [1:0][DATA_W-1:0]      req_wdata,
  output logic [1:0]                  grant,
  output logic [1:0]                  done,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  output logic                        sram_ren,
  output logic                        sram_wen,
  input  logic [DATA_W-1:0]           sram_rdata,
  input  logic [1:0]                  sram_state
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } state_t;

  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic                op_q, op_d;
  logic                last_q, last_d;
  logic                win;
  logic                hit;
  logic                fail;

`ifdef SRAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // On a tie the requester that did not win last time goes next.
  assign win = req[1] & (~req[0] | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    op_d    = op_q;
    last_d  = last_q;
    hit     = sram_state == ST_ACCESS;
    fail    = sram_state == ST_ERROR;
`ifdef SRAM_TIMEOUT_EN
    cnt_d = '0;
    if (state_q == ISSUE) cnt_d = cnt_q + 1'b1;
    fail = fail | (cnt_d == CNT_W'(TIMEOUT));
`endif
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        if (|req) begin
          addr_d  = req_addr[win];
          wdata_d = req_wdata[win];
          op_d    = req_write[win];
          ren_d   = ~req_write[win];
          wen_d   = req_write[win];
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hit) begin
          if (!op_q) rdata_d = sram_rdata;
          done_d  = grant_q;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = RELEASE;
        end else if (fail) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      op_q    <= 1'b0;
      last_q  <= 1'b1;
`ifdef SRAM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
      last_q  <= last_d;
`ifdef SRAM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ren   = ren_q;
  assign sram_wen   = wen_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Self-checking bench for sram_arbiter_ctrl with a behavioural SRAM wrapper.
// Define SRAM_TIMEOUT_EN to also exercise the ISSUE watchdog.
module tb_sram_arbiter_ctrl;

  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        req_write = '0;
  logic [1:0][9:0]   req_addr = '0;
  logic [1:0][31:0]  req_wdata = '0;
  logic [1:0]        grant, done;
  logic              err;
  logic [31:0]       rdata, sram_wdata, sram_rdata;
  logic [9:0]        sram_addr;
  logic              sram_ren, sram_wen;
  logic [1:0]        sram_state;

  logic [1:0]        mdl_state = 2'd0;
  int                busy_cnt = 0;
  bit   [31:0]       sram_mem [1024];
  logic [31:0]       mdl_rdata = '0;
  logic              force_en = 1'b0;
  logic [1:0]        force_val = 2'd0;
  int                err_seen = 0;

  bit   [31:0]       ref_mem [1024];
  logic [31:0]       rdata_m = '0;
  bit                last_m = 1'b1;
  logic [1:0]        seen_grant;

  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sram_arbiter_ctrl #(
    .ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_rdata(sram_rdata), .sram_state(sram_state)
  );

  // Wrapper: FREE -> 3x BUSY -> ACCESS while an enable is held.
  always @(posedge clk) begin
    if (!(sram_ren | sram_wen)) mdl_state <= 2'd0;
    else if (sram_ren & sram_wen) mdl_state <= 2'd3;
    else case (mdl_state)
      2'd0: begin mdl_state <= 2'd1; busy_cnt <= 1; end
      2'd1: begin
        if (busy_cnt == 3) begin
          mdl_state <= 2'd2;
          if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
          else mdl_rdata <= sram_mem[sram_addr];
        end else busy_cnt <= busy_cnt + 1;
      end
      default: ;
    endcase
    if (mdl_state == 2'd3) err_seen <= err_seen + 1;
  end

  assign sram_state = force_en ? force_val : mdl_state;
  assign sram_rdata = (mdl_state == 2'd2) ? mdl_rdata : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [9:0] a,
                         input logic [31:0] d);
    req[i] = 1'b1;
    req_write[i] = w;
    req_addr[i] = a;
    req_wdata[i] = d;
  endtask

  task automatic do_reset();
    req = '0;
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    last_m = 1'b1;
    rdata_m = '0;
    @(negedge clk);
  endtask

  // Call mid-cycle while the DUT is idle; returns mid-cycle, idle again.
  task automatic serve(input string tag, input bit drop, input int err_at,
                       input int chg_at, input bit hold);
    int w, n, en_cyc, lat;
    bit bad, eerr;
    logic [1:0] oh;
    logic [9:0] ea;
    logic ew;
    logic [31:0] ed;
    w = (req == 2'b11) ? (last_m ? 0 : 1) : (req[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    ea = req_addr[w];
    ew = req_write[w];
    ed = req_wdata[w];
    eerr = hold || (err_at != 0);
    lat = hold ? TIMEOUT + 1 : ((err_at != 0) ? err_at + 1 : 6);
    n = 0;
    en_cyc = 0;
    bad = 1'b0;
    if (hold) begin force_en = 1'b1; force_val = 2'd1; end
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) seen_grant = grant;
      if (sram_ren | sram_wen) begin
        en_cyc++;
        if (sram_addr !== ea || sram_ren !== !ew || sram_wen !== ew ||
            (ew && sram_wdata !== ed)) bad = 1'b1;
      end
      if (grant !== oh) bad = 1'b1;
      if (done !== 2'b00) break;
      if (n == err_at) begin force_en = 1'b1; force_val = 2'd3; end
      if (n == chg_at) req_addr[w] = ea ^ 10'h030;
    end
    force_en = 1'b0;
    last_m = w[0];
    if (!eerr) begin
      if (ew) ref_mem[ea] = ed;
      else rdata_m = ref_mem[ea];
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " done"}, 64'(done), 64'(oh));
    check({tag, " err"}, 64'(err), 64'(eerr));
    check({tag, " rdata"}, 64'(rdata), 64'(rdata_m));
    check({tag, " bus"}, 64'(bad ? 999 : en_cyc), 64'(lat - 1));
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, 64'({grant, done, err, sram_ren, sram_wen}), 64'd0);
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;
    rr_exp[3] = 2'b10;

    @(negedge clk);
    @(negedge clk);
    check("reset ctl", 64'({grant, done, err, sram_ren, sram_wen}), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    check("reset addr", 64'(sram_addr), 64'd0);
    check("reset wdata", 64'(sram_wdata), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    set_req(0, 1'b1, 10'h005, 32'hDEAD_BEEF);
    serve("wr5", 1'b1, 0, 0, 1'b0);
    set_req(0, 1'b0, 10'h005, 32'h0);
    serve("rd5", 1'b1, 0, 0, 1'b0);
    check("rd5 value", 64'(rdata), 64'hDEAD_BEEF);

    set_req(1, 1'b1, 10'h3FF, 32'h1234_5678);
    serve("wr3ff", 1'b1, 0, 0, 1'b0);
    set_req(1, 1'b0, 10'h3FF, 32'h0);
    serve("rd3ff", 1'b1, 0, 0, 1'b0);
    check("rd3ff value", 64'(rdata), 64'h1234_5678);

    set_req(0, 1'b1, 10'h010, 32'hA5A5_0010);
    serve("wr10", 1'b1, 0, 0, 1'b0);
    set_req(0, 1'b0, 10'h010, 32'h0);
    serve("stable", 1'b1, 0, 2, 1'b0);
    check("stable value", 64'(rdata), 64'hA5A5_0010);

    set_req(0, 1'b0, 10'h005, 32'h0);
    serve("error", 1'b1, 2, 0, 1'b0);

    set_req(0, 1'b0, 10'h005, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst pre ren", 64'(sram_ren), 64'd1);
    n_rst = 1'b0;
    #1;
    check("rst async", 64'({grant, done, err, sram_ren, sram_wen}), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    req = '0;
    n_rst = 1'b1;
    last_m = 1'b1;
    rdata_m = '0;
    @(negedge clk);
    set_req(1, 1'b0, 10'h3FF, 32'h0);
    serve("rst post", 1'b1, 0, 0, 1'b0);

    do_reset();
    set_req(0, 1'b0, 10'h005, 32'h0);
    set_req(1, 1'b0, 10'h3FF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      serve("contend", 1'b0, 0, 0, 1'b0);
      check($sformatf("rr order %0d", k), 64'(seen_grant), 64'(rr_exp[k]));
    end
    req = '0;
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 2; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                  $urandom);
      if (req == 2'b00)
        set_req(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                $urandom);
      serve("random", 1'b1, 0, 0, 1'b0);
    end
    if (req != 2'b00) begin
      serve("drain", 1'b1, 0, 0, 1'b0);
    end

`ifdef SRAM_TIMEOUT_EN
    set_req(0, 1'b0, 10'h005, 32'h0);
    serve("timeout", 1'b1, 0, 0, 1'b1);
`endif

    check("no sram error", 64'(err_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
